// File: rtl/uart_calc_pkg.sv
// Shared definitions for the UART calculator framer.
// Holds command/reply byte values, calculator select encodings,
// FSM state encodings and the command-to-select decode function.
package uart_calc_pkg;

    // Command bytes received from the host
    localparam logic [7:0] CMD_ADD  = 8'h41;  // "A"
    localparam logic [7:0] CMD_SUB  = 8'h53;  // "S"
    localparam logic [7:0] CMD_CMP  = 8'h43;  // "C"
    localparam logic [7:0] CMD_PING = 8'h50;  // "P"

    // Single-byte replies
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NACK  = 8'h15;
    localparam logic [7:0] RSP_ABORT = 8'h18;

    // Calculator operation select; SEL_NONE marks a non-calculation byte
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b11;
    localparam logic [1:0] SEL_CMP  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_RX_OP     = 3'd1;
    localparam state_t S_CALC      = 3'd2;
    localparam state_t S_CALC_WAIT = 3'd3;
    localparam state_t S_TX        = 3'd4;
    localparam state_t S_TX_WAIT   = 3'd5;

    // Map a command byte to its calculator select; SEL_NONE for ping/unknown
    function automatic logic [1:0] cmd_sel(input logic [7:0] cmd);
        logic [1:0] sel;
        case (cmd)
            CMD_ADD: sel = SEL_ADD;
            CMD_SUB: sel = SEL_SUB;
            CMD_CMP: sel = SEL_CMP;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// MSB-first reply buffer of NBYTES+1 bytes with a remaining-byte count.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_word    load the full word; all NBYTES+1 bytes pending
//   word         full reply word, first byte to send in the top bits
//   load_byte    load a single reply byte; one byte pending
//   byte_in      single reply byte
//   shift        drop the top byte (it has just been handed to the transmitter)
//   top_byte     byte currently at the top of the buffer
//   remaining    number of bytes still to send
module uart_tx_shifter
    import uart_calc_pkg::*;
#(
    parameter int NBYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_word,
    input  logic [(NBYTES+1)*8-1:0]       word,
    input  logic                          load_byte,
    input  logic [7:0]                    byte_in,
    input  logic                          shift,
    output logic [7:0]                    top_byte,
    output logic [$clog2(NBYTES+2)-1:0]   remaining
);

    localparam int W     = (NBYTES + 1) * 8;
    localparam int REM_W = $clog2(NBYTES + 2);

    logic [W-1:0]     buf_r;
    logic [REM_W-1:0] cnt_r;

    // Buffer and count: loads take priority over shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r <= {W{1'b0}};
            cnt_r <= {REM_W{1'b0}};
        end else if (load_word) begin
            buf_r <= word;
            cnt_r <= REM_W'(NBYTES + 1);
        end else if (load_byte) begin
            buf_r <= {byte_in, {(W-8){1'b0}}};
            cnt_r <= REM_W'(1);
        end else if (shift && (cnt_r != {REM_W{1'b0}})) begin
            buf_r <= {buf_r[W-9:0], 8'h00};
            cnt_r <= cnt_r - REM_W'(1);
        end else begin
            buf_r <= buf_r;
            cnt_r <= cnt_r;
        end
    end

    assign top_byte  = buf_r[W-1 -: 8];
    assign remaining = cnt_r;

endmodule

// File: rtl/uart_calc_framer.sv
// Byte-level protocol engine between a byte transport and the calculator.
// Receives a command byte and two big-endian operands, launches one
// calculation and returns the framed result MSB-first. Also answers ping
// (ACK), unknown commands (NACK), inter-byte timeouts (CAN) and flags
// bytes dropped while busy (oOverrun).
// Ports:
//   iClk/iRstn              clock, asynchronous active-low reset
//   iRxByte/iRxValid        received byte stream
//   oTxByte/oTxStart        transmit request, byte held until iTxDone
//   iTxBusy/iTxDone         transmitter status
//   oCalcStart/oCalcSel     calculation launch and operation select
//   oOpA/oOpB               operands, stable while the core computes
//   iCalcRes/iCalcDone      calculator result
//   oBusy                   high whenever not idle
//   oOverrun                sticky dropped-byte flag
module uart_calc_framer
    import uart_calc_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 512,
    parameter int TIMEOUT_CYCLES = 12_500_000
) (
    input  logic                     iClk,
    input  logic                     iRstn,
    input  logic [7:0]               iRxByte,
    input  logic                     iRxValid,
    output logic [7:0]               oTxByte,
    output logic                     oTxStart,
    input  logic                     iTxBusy,
    input  logic                     iTxDone,
    output logic                     oCalcStart,
    output logic [1:0]               oCalcSel,
    output logic [OPERAND_WIDTH-1:0] oOpA,
    output logic [OPERAND_WIDTH-1:0] oOpB,
    input  logic [OPERAND_WIDTH:0]   iCalcRes,
    input  logic                     iCalcDone,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int NBYTES = OPERAND_WIDTH / 8;
    localparam int CNT_W  = $clog2(2 * NBYTES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TXW    = (NBYTES + 1) * 8;
    localparam int REM_W  = $clog2(NBYTES + 2);

    state_t                   state_r, state_nxt_s;
    logic [1:0]               sel_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [TMR_W-1:0]         tmr_r;
    logic [OPERAND_WIDTH-1:0] op_a_r, op_b_r;

    logic [1:0]       cmd_sel_s;
    logic             expired_s, last_byte_s, tx_empty_s;
    logic             take_cmd_s, take_op_s, tmr_inc_s, calc_fire_s, tx_fire_s, drop_s;
    logic             load_word_s, load_byte_s;
    logic [7:0]       reply_byte_s;
    logic [TXW-1:0]   tx_word_s;
    logic [7:0]       tx_top_s;
    logic [REM_W-1:0] tx_left_s;

    assign cmd_sel_s   = cmd_sel(iRxByte);
    assign expired_s   = (tmr_r == TMR_W'(TIMEOUT_CYCLES));
    assign last_byte_s = (cnt_r == CNT_W'(2 * NBYTES - 1));
    assign tx_empty_s  = (tx_left_s == {REM_W{1'b0}});

    uart_tx_shifter #(.NBYTES(NBYTES)) u_tx_shifter (
        .clk       (iClk),
        .rst_n     (iRstn),
        .load_word (load_word_s),
        .word      (tx_word_s),
        .load_byte (load_byte_s),
        .byte_in   (reply_byte_s),
        .shift     (tx_fire_s),
        .top_byte  (tx_top_s),
        .remaining (tx_left_s)
    );

    // State register
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a byte arriving in the expiry cycle beats the abort
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (iRxValid) begin
                    state_nxt_s = (cmd_sel_s == SEL_NONE) ? S_TX : S_RX_OP;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RX_OP: begin
                if (iRxValid) begin
                    state_nxt_s = last_byte_s ? S_CALC : S_RX_OP;
                end else if (expired_s) begin
                    state_nxt_s = S_TX;
                end else begin
                    state_nxt_s = S_RX_OP;
                end
            end
            S_CALC:      state_nxt_s = S_CALC_WAIT;
            S_CALC_WAIT: state_nxt_s = iCalcDone ? S_TX : S_CALC_WAIT;
            S_TX: begin
                if (tx_empty_s) begin
                    state_nxt_s = S_IDLE;
                end else if (!iTxBusy) begin
                    state_nxt_s = S_TX_WAIT;
                end else begin
                    state_nxt_s = S_TX;
                end
            end
            S_TX_WAIT:   state_nxt_s = iTxDone ? S_TX : S_TX_WAIT;
            default:     state_nxt_s = S_IDLE;
        endcase
    end

    // Per-state actions driving the datapath, reply buffer and outputs
    always_comb begin
        take_cmd_s   = 1'b0;
        take_op_s    = 1'b0;
        tmr_inc_s    = 1'b0;
        calc_fire_s  = 1'b0;
        tx_fire_s    = 1'b0;
        drop_s       = 1'b0;
        load_word_s  = 1'b0;
        load_byte_s  = 1'b0;
        reply_byte_s = RSP_NACK;
        // Compare results are a single flag word aligned to the top of the frame
        tx_word_s    = (sel_r == SEL_CMP) ? {iCalcRes, 7'b0000000} : {7'b0000000, iCalcRes};
        case (state_r)
            S_IDLE: begin
                if (iRxValid) begin
                    take_cmd_s = 1'b1;
                    if (cmd_sel_s == SEL_NONE) begin
                        load_byte_s  = 1'b1;
                        reply_byte_s = (iRxByte == CMD_PING) ? RSP_ACK : RSP_NACK;
                    end else begin
                        load_byte_s  = 1'b0;
                    end
                end else begin
                    take_cmd_s = 1'b0;
                end
            end
            S_RX_OP: begin
                if (iRxValid) begin
                    take_op_s = 1'b1;
                end else if (expired_s) begin
                    load_byte_s  = 1'b1;
                    reply_byte_s = RSP_ABORT;
                end else begin
                    tmr_inc_s = 1'b1;
                end
            end
            S_CALC: begin
                calc_fire_s = 1'b1;
                drop_s      = iRxValid;
            end
            S_CALC_WAIT: begin
                load_word_s = iCalcDone;
                drop_s      = iRxValid;
            end
            S_TX: begin
                tx_fire_s = !tx_empty_s && !iTxBusy;
                drop_s    = iRxValid;
            end
            S_TX_WAIT: begin
                drop_s = iRxValid;
            end
            default: begin
                drop_s = 1'b0;
            end
        endcase
    end

    // Frame capture: select, byte counter, inter-byte timer, operand shifters
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            sel_r  <= 2'b00;
            cnt_r  <= {CNT_W{1'b0}};
            tmr_r  <= {TMR_W{1'b0}};
            op_a_r <= {OPERAND_WIDTH{1'b0}};
            op_b_r <= {OPERAND_WIDTH{1'b0}};
        end else if (take_cmd_s) begin
            sel_r <= cmd_sel_s;
            cnt_r <= {CNT_W{1'b0}};
            tmr_r <= {TMR_W{1'b0}};
        end else if (take_op_s) begin
            if (cnt_r < CNT_W'(NBYTES)) begin
                op_a_r <= {op_a_r[OPERAND_WIDTH-9:0], iRxByte};
            end else begin
                op_b_r <= {op_b_r[OPERAND_WIDTH-9:0], iRxByte};
            end
            cnt_r <= cnt_r + CNT_W'(1);
            tmr_r <= {TMR_W{1'b0}};
        end else if (tmr_inc_s) begin
            tmr_r <= tmr_r + TMR_W'(1);
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Registered outputs
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            oTxByte    <= 8'h00;
            oTxStart   <= 1'b0;
            oCalcStart <= 1'b0;
            oCalcSel   <= 2'b00;
            oOpA       <= {OPERAND_WIDTH{1'b0}};
            oOpB       <= {OPERAND_WIDTH{1'b0}};
            oBusy      <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            oTxStart   <= tx_fire_s;
            oCalcStart <= calc_fire_s;
            oBusy      <= (state_nxt_s != S_IDLE);
            if (tx_fire_s) begin
                oTxByte <= tx_top_s;
            end else begin
                oTxByte <= oTxByte;
            end
            if (calc_fire_s) begin
                oOpA     <= op_a_r;
                oOpB     <= op_b_r;
                oCalcSel <= sel_r;
            end else begin
                oOpA     <= oOpA;
                oOpB     <= oOpB;
                oCalcSel <= oCalcSel;
            end
            if (take_cmd_s) begin
                oOverrun <= 1'b0;
            end else if (drop_s) begin
                oOverrun <= 1'b1;
            end else begin
                oOverrun <= oOverrun;
            end
        end
    end

endmodule
